// File: rtl/mux_arb_n.sv
// N-way, W-bit selector with a registered valid/ready output stage.
// Selection is by external select, round-robin, or fixed priority (MODE).
module mux_arb_n #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 2,
  parameter int MODE   = 0,
  localparam int SEL_W = (NUM_IN > 2) ? $clog2(NUM_IN) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [SEL_W-1:0]          sel,
  input  logic [NUM_IN*WIDTH-1:0]   in_data,
  input  logic [NUM_IN-1:0]         in_valid,
  output logic [NUM_IN-1:0]         in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_src,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_src_q, out_src_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

  logic             load;
  logic             grant_valid;
  logic [SEL_W-1:0] grant_idx;
  logic [WIDTH-1:0] grant_data;
  logic             xfer;

  always_comb begin
    load        = !out_valid_q || out_ready;
    grant_valid = 1'b0;
    grant_idx   = '0;

    if (MODE == 0) begin
      // An out-of-range sel matches no channel, so it never grants.
      for (int i = 0; i < NUM_IN; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          grant_valid = 1'b1;
          grant_idx   = SEL_W'(i);
        end
      end
    end else if (MODE == 1) begin
      // Search rr_ptr..NUM_IN-1 first, then wrap to 0..rr_ptr-1.
      for (int i = 0; i < NUM_IN; i++) begin
        if (!grant_valid && in_valid[i] && SEL_W'(i) >= rr_ptr_q) begin
          grant_valid = 1'b1;
          grant_idx   = SEL_W'(i);
        end
      end
      for (int i = 0; i < NUM_IN; i++) begin
        if (!grant_valid && in_valid[i]) begin
          grant_valid = 1'b1;
          grant_idx   = SEL_W'(i);
        end
      end
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (!grant_valid && in_valid[i]) begin
          grant_valid = 1'b1;
          grant_idx   = SEL_W'(i);
        end
      end
    end

    xfer       = rst_n && load && grant_valid;
    grant_data = '0;
    in_ready   = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_idx == SEL_W'(i)) begin
        grant_data  = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = xfer;
      end
    end

    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      out_valid_d = grant_valid;
      if (grant_valid) begin
        out_data_d = grant_data;
        out_src_d  = grant_idx;
        rr_ptr_d   = (grant_idx == SEL_W'(NUM_IN - 1)) ? '0 : grant_idx + SEL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_arb_n.sv
// Directed bench for mux_arb_n: one instance per mode/size of interest,
// table-driven vectors for round-robin and priority, hand sequences for the rest.
module tb_mux_arb_n;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // u0: MODE 0, NUM_IN 2
  logic [0:0]  sel0 = '0;
  logic [15:0] data0 = '0;
  logic [1:0]  vld0 = '0, rdy0;
  logic [7:0]  odata0;
  logic [0:0]  src0;
  logic        ovld0, ordy0 = 1'b1;

  // u1: MODE 1, NUM_IN 4
  logic [1:0]  sel1 = '0;
  logic [31:0] data1 = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
  logic [3:0]  vld1 = '0, rdy1;
  logic [7:0]  odata1;
  logic [1:0]  src1;
  logic        ovld1, ordy1 = 1'b1;

  // u2: MODE 2, NUM_IN 4
  logic [1:0]  sel2 = '0;
  logic [31:0] data2 = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
  logic [3:0]  vld2 = '0, rdy2;
  logic [7:0]  odata2;
  logic [1:0]  src2;
  logic        ovld2, ordy2 = 1'b1;

  // u3: MODE 0, NUM_IN 3
  logic [1:0]  sel3 = '0;
  logic [23:0] data3 = {8'h32, 8'h31, 8'h30};
  logic [2:0]  vld3 = '0, rdy3;
  logic [7:0]  odata3;
  logic [1:0]  src3;
  logic        ovld3, ordy3 = 1'b1;

  mux_arb_n #(.WIDTH(8), .NUM_IN(2), .MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .sel(sel0), .in_data(data0), .in_valid(vld0),
    .in_ready(rdy0), .out_data(odata0), .out_src(src0), .out_valid(ovld0),
    .out_ready(ordy0));

  mux_arb_n #(.WIDTH(8), .NUM_IN(4), .MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .sel(sel1), .in_data(data1), .in_valid(vld1),
    .in_ready(rdy1), .out_data(odata1), .out_src(src1), .out_valid(ovld1),
    .out_ready(ordy1));

  mux_arb_n #(.WIDTH(8), .NUM_IN(4), .MODE(2)) u2 (
    .clk(clk), .rst_n(rst_n), .sel(sel2), .in_data(data2), .in_valid(vld2),
    .in_ready(rdy2), .out_data(odata2), .out_src(src2), .out_valid(ovld2),
    .out_ready(ordy2));

  mux_arb_n #(.WIDTH(8), .NUM_IN(3), .MODE(0)) u3 (
    .clk(clk), .rst_n(rst_n), .sel(sel3), .in_data(data3), .in_valid(vld3),
    .in_ready(rdy3), .out_data(odata3), .out_src(src3), .out_valid(ovld3),
    .out_ready(ordy3));

  typedef struct {
    int         dut;
    logic [3:0] vld;
    logic       ordy;
    logic [3:0] exp_rdy;
    logic [1:0] exp_src;
    logic       exp_valid;
    string      name;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    else
      pass_cnt++;
  endtask

  task automatic step(input vec_t v);
    logic [7:0] base;
    vld1 = '0;
    vld2 = '0;
    if (v.dut == 1) begin
      vld1 = v.vld; ordy1 = v.ordy; base = 8'hC0;
    end else begin
      vld2 = v.vld; ordy2 = v.ordy; base = 8'hD0;
    end
    #1;
    check({v.name, ".rdy"}, (v.dut == 1) ? 32'(rdy1) : 32'(rdy2), 32'(v.exp_rdy));
    @(posedge clk); #1;
    check({v.name, ".src"},   (v.dut == 1) ? 32'(src1)   : 32'(src2),   32'(v.exp_src));
    check({v.name, ".valid"}, (v.dut == 1) ? 32'(ovld1)  : 32'(ovld2),  32'(v.exp_valid));
    check({v.name, ".data"},  (v.dut == 1) ? 32'(odata1) : 32'(odata2), 32'(base + 8'(v.exp_src)));
  endtask

  // Drive u0, check its in_ready now and its registered outputs after the next edge.
  task automatic step0(input string nm, input logic [0:0] s, input logic [1:0] v, input logic r,
                       input logic [1:0] erdy, input logic [7:0] edata, input logic [0:0] esrc,
                       input logic evld);
    sel0 = s; vld0 = v; ordy0 = r;
    #1;
    check({nm, ".rdy"}, 32'(rdy0), 32'(erdy));
    @(posedge clk); #1;
    check({nm, ".data"},  32'(odata0), 32'(edata));
    check({nm, ".src"},   32'(src0),   32'(esrc));
    check({nm, ".valid"}, 32'(ovld0),  32'(evld));
  endtask

  task automatic step3(input string nm, input logic [1:0] s, input logic [2:0] v, input logic r,
                       input logic [2:0] erdy, input logic [7:0] edata, input logic [1:0] esrc,
                       input logic evld);
    sel3 = s; vld3 = v; ordy3 = r;
    #1;
    check({nm, ".rdy"}, 32'(rdy3), 32'(erdy));
    @(posedge clk); #1;
    check({nm, ".data"},  32'(odata3), 32'(edata));
    check({nm, ".src"},   32'(src3),   32'(esrc));
    check({nm, ".valid"}, 32'(ovld3),  32'(evld));
  endtask

  initial begin
    // Round-robin: full rotation, skip of ch2, stalls, idle, and wrap from rr_ptr=3.
    tbl.push_back('{1, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, "rr_a0"});
    tbl.push_back('{1, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, "rr_a1"});
    tbl.push_back('{1, 4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, "rr_a2"});
    tbl.push_back('{1, 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, "rr_a3"});
    tbl.push_back('{1, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, "rr_a4"});
    tbl.push_back('{1, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, "rr_a5"});
    tbl.push_back('{1, 4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, "rr_a6"});
    tbl.push_back('{1, 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, "rr_a7"});
    tbl.push_back('{1, 4'b1011, 1'b1, 4'b0001, 2'd0, 1'b1, "rr_s0"});
    tbl.push_back('{1, 4'b1011, 1'b1, 4'b0010, 2'd1, 1'b1, "rr_s1"});
    tbl.push_back('{1, 4'b1011, 1'b1, 4'b1000, 2'd3, 1'b1, "rr_s2"});
    tbl.push_back('{1, 4'b1011, 1'b1, 4'b0001, 2'd0, 1'b1, "rr_s3"});
    tbl.push_back('{1, 4'b1011, 1'b1, 4'b0010, 2'd1, 1'b1, "rr_s4"});
    tbl.push_back('{1, 4'b1011, 1'b1, 4'b1000, 2'd3, 1'b1, "rr_s5"});
    tbl.push_back('{1, 4'b1111, 1'b0, 4'b0000, 2'd3, 1'b1, "rr_st0"});
    tbl.push_back('{1, 4'b1111, 1'b0, 4'b0000, 2'd3, 1'b1, "rr_st1"});
    tbl.push_back('{1, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, "rr_rel"});
    tbl.push_back('{1, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, "rr_idle"});
    tbl.push_back('{1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, "rr_empty_ld"});
    tbl.push_back('{1, 4'b1111, 1'b0, 4'b0000, 2'd2, 1'b1, "rr_st2"});
    tbl.push_back('{1, 4'b0011, 1'b1, 4'b0001, 2'd0, 1'b1, "rr_wrap"});
    // Fixed priority.
    tbl.push_back('{2, 4'b1010, 1'b1, 4'b0010, 2'd1, 1'b1, "pr_0"});
    tbl.push_back('{2, 4'b1010, 1'b1, 4'b0010, 2'd1, 1'b1, "pr_1"});
    tbl.push_back('{2, 4'b1010, 1'b1, 4'b0010, 2'd1, 1'b1, "pr_2"});
    tbl.push_back('{2, 4'b1000, 1'b1, 4'b1000, 2'd3, 1'b1, "pr_3"});
    tbl.push_back('{2, 4'b1011, 1'b1, 4'b0001, 2'd0, 1'b1, "pr_4"});
    tbl.push_back('{2, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, "pr_idle"});
    tbl.push_back('{2, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, "pr_empty_ld"});
    tbl.push_back('{2, 4'b0001, 1'b0, 4'b0000, 2'd3, 1'b1, "pr_stall"});

    // Reset: in_ready must stay low even with every input valid.
    vld1 = 4'b1111;
    #1;
    check("rst_rdy1", 32'(rdy1), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    check("rst_rdy1b", 32'(rdy1), 32'd0);
    check("rst_ovld0", 32'(ovld0), 32'd0);
    check("rst_odata0", 32'(odata0), 32'd0);
    check("rst_src0", 32'(src0), 32'd0);
    check("rst_ovld1", 32'(ovld1), 32'd0);
    check("rst_odata1", 32'(odata1), 32'd0);
    check("rst_src1", 32'(src1), 32'd0);
    check("rst_ovld2", 32'(ovld2), 32'd0);
    check("rst_ovld3", 32'(ovld3), 32'd0);
    vld1 = '0;
    rst_n = 1'b1;

    foreach (tbl[k]) step(tbl[k]);
    vld1 = '0;
    vld2 = '0;

    // External select, then a three-cycle stall with inputs and sel moving.
    data0 = {8'hA5, 8'h3C};
    step0("m0_sel1", 1'b1, 2'b11, 1'b1, 2'b10, 8'hA5, 1'b1, 1'b1);
    step0("m0_sel0", 1'b0, 2'b11, 1'b1, 2'b01, 8'h3C, 1'b0, 1'b1);
    data0 = {8'hA5, 8'h55};
    step0("m0_ld55", 1'b0, 2'b11, 1'b1, 2'b01, 8'h55, 1'b0, 1'b1);
    data0 = {8'h22, 8'h11};
    step0("m0_stall0", 1'b1, 2'b11, 1'b0, 2'b00, 8'h55, 1'b0, 1'b1);
    step0("m0_stall1", 1'b0, 2'b01, 1'b0, 2'b00, 8'h55, 1'b0, 1'b1);
    step0("m0_stall2", 1'b1, 2'b10, 1'b0, 2'b00, 8'h55, 1'b0, 1'b1);
    step0("m0_release", 1'b1, 2'b11, 1'b1, 2'b10, 8'h22, 1'b1, 1'b1);
    step0("m0_nogrant", 1'b1, 2'b01, 1'b1, 2'b00, 8'h22, 1'b1, 1'b0);
    vld0 = '0;

    // NUM_IN=3: sel=3 is out of range and must never grant.
    step3("m0n3_sel2", 2'd2, 3'b111, 1'b1, 3'b100, 8'h32, 2'd2, 1'b1);
    step3("m0n3_sel3", 2'd3, 3'b111, 1'b1, 3'b000, 8'h32, 2'd2, 1'b0);
    step3("m0n3_sel3b", 2'd3, 3'b111, 1'b0, 3'b000, 8'h32, 2'd2, 1'b0);
    vld3 = '0;

    // Round-robin reset mid-stream with rr_ptr=2 and a word pending.
    step('{1, 4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1, "rr_pre_rst"});
    vld1 = 4'b1111;
    ordy1 = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_rdy", 32'(rdy1), 32'd0);
    @(posedge clk); #1;
    check("mid_rst_ovld", 32'(ovld1), 32'd0);
    check("mid_rst_data", 32'(odata1), 32'd0);
    check("mid_rst_src", 32'(src1), 32'd0);
    rst_n = 1'b1;
    ordy1 = 1'b1;
    #1;
    check("post_rst_rdy", 32'(rdy1), 32'b0001);
    @(posedge clk); #1;
    check("post_rst_src", 32'(src1), 32'd0);
    check("post_rst_data", 32'(odata1), 32'hC0);
    check("post_rst_ovld", 32'(ovld1), 32'd1);
    vld1 = '0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
